// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush scheduler:
//   - syscall drain FSM state encoding (legacy constants + enum view)
//   - REG_ZERO, the hard-wired zero register that never carries a dependency
//   - default drain length
//   - src_hit(): one-source register dependency compare
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_NOTIFY  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    DRAIN   = ST_DRAIN,
    NOTIFY  = ST_NOTIFY,
    RELEASE = ST_RELEASE
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DRAIN_CYCLES_DEF = 4;

  // A consumed source depends on a writer when the register numbers agree;
  // $0 is constant, so it can never be a true dependency.
  function automatic logic src_hit(input logic       uses,
                                   input logic [4:0] src,
                                   input logic [4:0] dst);
    return uses && (src == dst) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard/stall scheduler.
//   ID_*   : instruction currently decoded in ID
//   EXE_*  : destination of the instruction in EXE
//   MEM_*  : destination of the instruction in MEM
//   Stall_IF/Stall_ID/Bubble_EXE/Flush_IF : per-cycle pipeline control
//   SYS/DrainActive : syscall sequencing status
//   StallCount/RedirectCount : performance counters (CNT_W wide)
// Modports: slave = scheduler side, master = datapath side.
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ID_Valid_IN;
  logic [4:0]       ID_RegA_IN;
  logic [4:0]       ID_RegB_IN;
  logic             ID_UsesA_IN;
  logic             ID_UsesB_IN;
  logic             ID_Syscall_IN;
  logic             ID_IsLLSC_IN;
  logic             ID_Redirect_IN;
  logic [4:0]       EXE_WriteReg_IN;
  logic             EXE_RegWrite_IN;
  logic             EXE_MemRead_IN;
  logic [4:0]       MEM_WriteReg_IN;
  logic             MEM_RegWrite_IN;

  logic             Stall_IF;
  logic             Stall_ID;
  logic             Bubble_EXE;
  logic             Flush_IF;
  logic             SYS;
  logic             DrainActive;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] RedirectCount;

  modport slave (
    input  ID_Valid_IN, ID_RegA_IN, ID_RegB_IN, ID_UsesA_IN, ID_UsesB_IN,
           ID_Syscall_IN, ID_IsLLSC_IN, ID_Redirect_IN,
           EXE_WriteReg_IN, EXE_RegWrite_IN, EXE_MemRead_IN,
           MEM_WriteReg_IN, MEM_RegWrite_IN,
    output Stall_IF, Stall_ID, Bubble_EXE, Flush_IF, SYS, DrainActive,
           StallCount, RedirectCount
  );

  modport master (
    output ID_Valid_IN, ID_RegA_IN, ID_RegB_IN, ID_UsesA_IN, ID_UsesB_IN,
           ID_Syscall_IN, ID_IsLLSC_IN, ID_Redirect_IN,
           EXE_WriteReg_IN, EXE_RegWrite_IN, EXE_MemRead_IN,
           MEM_WriteReg_IN, MEM_RegWrite_IN,
    input  Stall_IF, Stall_ID, Bubble_EXE, Flush_IF, SYS, DrainActive,
           StallCount, RedirectCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational load-use (LU) detector for the ID instruction.
// Inputs : ID source registers + use flags, EXE and MEM destinations.
// Output : lu -- ID must wait because a used source is not yet available.
// Build option FORWARDING_EN:
//   defined   : only a load in EXE is a hazard (bypasses cover the rest)
//   undefined : any register writer in EXE or MEM is a hazard
// Writeback is never a hazard: the register file forwards same-cycle data.
// -----------------------------------------------------------------------------
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] reg_a,
  input  logic [4:0] reg_b,
  input  logic       uses_a,
  input  logic       uses_b,
  input  logic [4:0] exe_wreg,
  input  logic       exe_reg_write,
  input  logic       exe_mem_read,
  input  logic [4:0] mem_wreg,
  input  logic       mem_reg_write,
  output logic       lu
);

  logic exe_hit;
  logic mem_hit;
  logic exe_haz;
  logic mem_haz;

  assign exe_hit = src_hit(uses_a, reg_a, exe_wreg) | src_hit(uses_b, reg_b, exe_wreg);
  assign mem_hit = src_hit(uses_a, reg_a, mem_wreg) | src_hit(uses_b, reg_b, mem_wreg);

`ifdef FORWARDING_EN
  logic unused_mem_write;
  assign unused_mem_write = mem_reg_write;
  assign exe_haz = exe_reg_write & exe_mem_read;
  assign mem_haz = 1'b0;
`else
  logic unused_mem_read;
  assign unused_mem_read = exe_mem_read;
  assign exe_haz = exe_reg_write;
  assign mem_haz = mem_reg_write;
`endif

  assign lu = id_valid & ((exe_haz & exe_hit) | (mem_haz & mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush scheduler sitting beside ID of the 5-stage MIPS pipeline.
// Ports:
//   CLK   : pipeline clock
//   RESET : synchronous, active-high reset
//   bus   : pipeline_hazard_ctrl_if.slave (ID/EXE/MEM status in,
//           Stall_IF/Stall_ID/Bubble_EXE/Flush_IF/SYS/DrainActive and
//           StallCount/RedirectCount out)
// Parameters:
//   DRAIN_CYCLES (1..7) : bubbles inserted ahead of a syscall before SYS
//   CNT_W               : performance counter width
// Build option: FORWARDING_EN selects the hazard writer set (see hazard_match).
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             llsc_q, llsc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic lu;
  logic start;
  logic stall;
  logic flush;

  hazard_match u_hazard_match (
    .id_valid      (bus.ID_Valid_IN),
    .reg_a         (bus.ID_RegA_IN),
    .reg_b         (bus.ID_RegB_IN),
    .uses_a        (bus.ID_UsesA_IN),
    .uses_b        (bus.ID_UsesB_IN),
    .exe_wreg      (bus.EXE_WriteReg_IN),
    .exe_reg_write (bus.EXE_RegWrite_IN),
    .exe_mem_read  (bus.EXE_MemRead_IN),
    .mem_wreg      (bus.MEM_WriteReg_IN),
    .mem_reg_write (bus.MEM_RegWrite_IN),
    .lu            (lu)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    llsc_d  = llsc_q;
    start   = 1'b0;
    stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A syscall outranks a load-use: both stall, but only the syscall
        // starts the drain.
        if (bus.ID_Valid_IN && bus.ID_Syscall_IN) begin
          start   = 1'b1;
          stall   = 1'b1;
          llsc_d  = bus.ID_IsLLSC_IN;
          cnt_d   = DRAIN_LOAD;
          // With a single drain cycle the start cycle is the only bubble,
          // so NOTIFY follows immediately.
          state_d = (DRAIN_LOAD == 3'd0) ? NOTIFY : DRAIN;
        end else begin
          stall = lu;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = NOTIFY;
      end
      NOTIFY: begin
        stall   = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        // The syscall leaves ID now; whatever sits in ID is not re-examined.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    flush       = bus.ID_Valid_IN & bus.ID_Redirect_IN & ~stall;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
    redir_cnt_d = redir_cnt_q + {{(CNT_W-1){1'b0}}, flush};
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      llsc_q      <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      llsc_q      <= llsc_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.Stall_IF      = stall;
  assign bus.Stall_ID      = stall;
  assign bus.Bubble_EXE    = stall;
  assign bus.Flush_IF      = flush;
  // LL/SC kind is captured at sequence start so SYS depends on flops only.
  assign bus.SYS           = (state_q == NOTIFY) & ~llsc_q;
  assign bus.DrainActive   = (state_q != IDLE);
  assign bus.StallCount    = stall_cnt_q;
  assign bus.RedirectCount = redir_cnt_q;

  logic unused_start;
  assign unused_start = start;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed vectors for pipeline_hazard_ctrl (DRAIN_CYCLES=4). Each stimulus
// cycle pushes its hand-computed expected outputs into a queue; a monitor
// pops one entry per cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst, valid;
    logic [4:0] ra, rb;
    logic       ua, ub, sys, llsc, redir;
    logic [4:0] ew;
    logic       erw, emr;
    logic [4:0] mw;
    logic       mrw;
  } in_t;

  typedef struct {
    string       tag;
    logic        stall, flush, sys, drain;
    logic [31:0] sc, rc;
  } exp_t;

  exp_t exp_q[$];
  in_t  vin;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   stim_done = 1'b0;

`ifdef FORWARDING_EN
  localparam int LU_N  = 1;  // stall cycles for the lw -> add case
  localparam int ALU_N = 0;  // ALU writer in EXE is bypassed
`else
  localparam int LU_N  = 2;
  localparam int ALU_N = 1;
`endif
  localparam int S0 = LU_N + ALU_N;  // stalls before the redirect tests
  localparam int S1 = S0 + 1;        // after redirect-with-LU
  localparam int S2 = S1 + 10;       // after syscall and LL sequences

  function automatic in_t nop();
    in_t v;
    v = '{rst:1'b0, valid:1'b0, ra:5'd0, rb:5'd0, ua:1'b0, ub:1'b0, sys:1'b0,
          llsc:1'b0, redir:1'b0, ew:5'd0, erw:1'b0, emr:1'b0, mw:5'd0, mrw:1'b0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic apply(input in_t v);
    rst                 = v.rst;
    bus.ID_Valid_IN     = v.valid;
    bus.ID_RegA_IN      = v.ra;
    bus.ID_RegB_IN      = v.rb;
    bus.ID_UsesA_IN     = v.ua;
    bus.ID_UsesB_IN     = v.ub;
    bus.ID_Syscall_IN   = v.sys;
    bus.ID_IsLLSC_IN    = v.llsc;
    bus.ID_Redirect_IN  = v.redir;
    bus.EXE_WriteReg_IN = v.ew;
    bus.EXE_RegWrite_IN = v.erw;
    bus.EXE_MemRead_IN  = v.emr;
    bus.MEM_WriteReg_IN = v.mw;
    bus.MEM_RegWrite_IN = v.mrw;
  endtask

  // One pipeline cycle: drive vin just after the edge, queue the expectation.
  task automatic cyc(input string tag, input logic st, input logic fl, input logic sy,
                     input logic dr, input int sc, input int rc);
    exp_t e;
    @(posedge clk);
    #1;
    apply(vin);
    e.tag = tag; e.stall = st; e.flush = fl; e.sys = sy; e.drain = dr;
    e.sc = 32'(sc); e.rc = 32'(rc);
    exp_q.push_back(e);
  endtask

  // Monitor: compare mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".stall_if"}, 32'(bus.Stall_IF),    32'(e.stall));
        check({e.tag, ".stall_id"}, 32'(bus.Stall_ID),    32'(e.stall));
        check({e.tag, ".bubble"},   32'(bus.Bubble_EXE),  32'(e.stall));
        check({e.tag, ".flush"},    32'(bus.Flush_IF),    32'(e.flush));
        check({e.tag, ".sys"},      32'(bus.SYS),         32'(e.sys));
        check({e.tag, ".drain"},    32'(bus.DrainActive), 32'(e.drain));
        check({e.tag, ".stallcnt"}, bus.StallCount,       e.sc);
        check({e.tag, ".redircnt"}, bus.RedirectCount,    e.rc);
      end
    end
  end

  initial begin
    vin = nop();
    vin.rst = 1'b1;
    apply(vin);
    repeat (2) @(posedge clk);

    // Reset state
    vin = nop();
    cyc("rst_state", 0, 0, 0, 0, 0, 0);

    // Load-use: lw $8 in EXE, add reads $8 on A
    vin = nop(); vin.valid = 1; vin.ra = 8; vin.ua = 1; vin.rb = 9; vin.ub = 1;
    vin.ew = 8; vin.erw = 1; vin.emr = 1;
    cyc("lu_exe", 1, 0, 0, 0, 0, 0);
    vin.erw = 0; vin.emr = 0; vin.ew = 0; vin.mw = 8; vin.mrw = 1;
    cyc("lu_mem", (LU_N == 2), 0, 0, 0, 1, 0);
    vin.mw = 0; vin.mrw = 0;
    cyc("lu_done", 0, 0, 0, 0, LU_N, 0);

    // Register 0 never matches
    vin = nop(); vin.valid = 1; vin.ua = 1; vin.ub = 1; vin.erw = 1; vin.emr = 1;
    cyc("reg0", 0, 0, 0, 0, LU_N, 0);

    // ALU writer in EXE: hazard only without forwarding
    vin = nop(); vin.valid = 1; vin.rb = 5; vin.ub = 1; vin.ew = 5; vin.erw = 1;
    cyc("alu_exe", (ALU_N == 1), 0, 0, 0, LU_N, 0);

    // Source not consumed
    vin = nop(); vin.valid = 1; vin.ra = 7; vin.ew = 7; vin.erw = 1; vin.emr = 1;
    cyc("unused_src", 0, 0, 0, 0, S0, 0);

    // Redirect without hazard, then concurrent with LU
    vin = nop(); vin.valid = 1; vin.redir = 1;
    cyc("redir", 0, 1, 0, 0, S0, 0);
    vin.ra = 8; vin.ua = 1; vin.ew = 8; vin.erw = 1; vin.emr = 1;
    cyc("redir_lu", 1, 0, 0, 0, S0, 1);
    vin = nop();
    cyc("after_redir", 0, 0, 0, 0, S1, 1);

    // Syscall held in ID: stalls t..t+4, SYS at t+4, RELEASE at t+5
    vin = nop(); vin.valid = 1; vin.sys = 1;
    cyc("sc_start", 1, 0, 0, 0, S1, 1);
    cyc("sc_drain1", 1, 0, 0, 1, S1 + 1, 1);
    cyc("sc_drain2", 1, 0, 0, 1, S1 + 2, 1);
    cyc("sc_drain3", 1, 0, 0, 1, S1 + 3, 1);
    cyc("sc_notify", 1, 0, 1, 1, S1 + 4, 1);
    cyc("sc_release", 0, 0, 0, 1, S1 + 5, 1);

    // LL enters ID right after RELEASE: fresh sequence, never SYS
    vin = nop(); vin.valid = 1; vin.sys = 1; vin.llsc = 1;
    cyc("ll_start", 1, 0, 0, 0, S1 + 5, 1);
    cyc("ll_drain1", 1, 0, 0, 1, S1 + 6, 1);
    vin.redir = 1;
    cyc("ll_drain2_redir", 1, 0, 0, 1, S1 + 7, 1);
    vin.redir = 0;
    cyc("ll_drain3", 1, 0, 0, 1, S1 + 8, 1);
    cyc("ll_notify", 1, 0, 0, 1, S1 + 9, 1);
    vin.ra = 8; vin.ua = 1; vin.ew = 8; vin.erw = 1; vin.emr = 1;
    cyc("ll_release_lu", 0, 0, 0, 1, S1 + 10, 1);
    vin = nop();
    cyc("ll_idle", 0, 0, 0, 0, S2, 1);

    // Reset mid-DRAIN aborts without SYS
    vin = nop(); vin.valid = 1; vin.sys = 1;
    cyc("rd_start", 1, 0, 0, 0, S2, 1);
    cyc("rd_drain1", 1, 0, 0, 1, S2 + 1, 1);
    vin.rst = 1;
    cyc("rd_reset", 1, 0, 0, 1, S2 + 2, 1);
    vin = nop();
    cyc("rd_after", 0, 0, 0, 0, 0, 0);
    cyc("rd_quiet", 0, 0, 0, 0, 0, 0);
    vin.valid = 1; vin.redir = 1;
    cyc("rd_redir", 0, 1, 0, 0, 0, 0);
    vin = nop();
    cyc("rd_redir_cnt", 0, 0, 0, 0, 0, 1);

    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage MIPS pipeline. It sits beside ID and decides each cycle whether IF/ID hold, whether EXE receives a bubble, and whether IF discards its fetched instruction after a taken branch or jump. It also runs the syscall drain sequence: hold the syscall in ID until older instructions retire, then pulse SYS to the simulator. Counters expose stall and redirect statistics to the branch-predictor evaluation flow.

## Interface
Parameters:
- DRAIN_CYCLES, 4, bubble cycles inserted ahead of a syscall before SYS is raised (legal 1..7)
- CNT_W, 32, width of the performance counters

Ports:
- CLK  in  1  pipeline clock
- RESET  in  1  synchronous, active-high reset
- ID_Valid_IN  in  1  ID holds a real instruction
- ID_RegA_IN / ID_RegB_IN  in  5 each  source registers read by the ID instruction
- ID_UsesA_IN / ID_UsesB_IN  in  1 each  the source is actually consumed
- ID_Syscall_IN  in  1  ID instruction is syscall, LL or SC
- ID_IsLLSC_IN  in  1  ID instruction is LL or SC (flush only, no SYS)
- ID_Redirect_IN  in  1  ID resolved a taken branch or jump this cycle
- EXE_WriteReg_IN  in  5;  EXE_RegWrite_IN, EXE_MemRead_IN  in  1  instruction currently in EXE
- MEM_WriteReg_IN  in  5;  MEM_RegWrite_IN  in  1  instruction currently in MEM
- Stall_IF  out  1  hold PC and IF/ID
- Stall_ID  out  1  hold the ID instruction
- Bubble_EXE  out  1  EXE latches a NOP instead of ID outputs
- Flush_IF  out  1  discard the instruction fetched this cycle
- SYS  out  1  simulator system-call request
- DrainActive  out  1  syscall sequence in progress
- StallCount  out  CNT_W  cycles with Stall_ID=1
- RedirectCount  out  CNT_W  accepted redirects

## Operation
- Load-use hazard (LU): ID_Valid_IN and a used source matches a hazard-producing writer. Register 0 never matches. The writer set is defined under Configuration.
- FSM states: IDLE, DRAIN, NOTIFY, RELEASE. State is registered.
- IDLE:
  - ID_Valid_IN & ID_Syscall_IN goes to DRAIN and loads cnt=DRAIN_CYCLES-1.
  - LU has lower priority than the syscall.
- DRAIN: cnt decrements each cycle. At cnt==0, go to NOTIFY.
- NOTIFY: SYS=~ID_IsLLSC_IN. Go to RELEASE.
- RELEASE: the syscall advances to EXE. Go to IDLE unconditionally. The instruction in ID during RELEASE is not re-examined for syscall.
- Stall_IF=Stall_ID=Bubble_EXE=1 in two cases:
  - (IDLE & starting a sequence) or DRAIN or NOTIFY;
  - IDLE & LU.
- In RELEASE all three are 0.
- DrainActive=1 in DRAIN, NOTIFY and RELEASE.
- Flush_IF = ID_Valid_IN & ID_Redirect_IN & ~Stall_ID. A redirect on a stalled cycle is ignored because ID re-resolves it next cycle.
- StallCount increments on every cycle with Stall_ID=1.
- RedirectCount increments on every cycle with Flush_IF=1.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Stall_IF, Stall_ID, Bubble_EXE and Flush_IF are combinational from the inputs and state, valid in the same cycle.
- SYS and DrainActive decode from registered state only, so they are glitch-free.
- Syscall first seen in ID at cycle t:
  - stalls cover t..t+DRAIN_CYCLES;
  - SYS is high in cycle t+DRAIN_CYCLES (NOTIFY);
  - RELEASE is at t+DRAIN_CYCLES+1;
  - the syscall occupies ID for DRAIN_CYCLES+2 cycles.
- Back-to-back syscalls: the second one enters ID after RELEASE and starts a fresh sequence the following cycle.
- LU stalls last exactly as long as the match persists. No state is kept.
- RESET (sync, high) forces the following on the next edge:
  - state=IDLE, cnt=0, both counters 0;
  - SYS=0, DrainActive=0.
- Reset asserted mid-sequence aborts it without raising SYS.

## Configuration
- FORWARDING_EN defined: only a load in EXE is a hazard writer (EXE_MemRead_IN & EXE_RegWrite_IN). Bypass paths cover everything else.
- FORWARDING_EN undefined: any EXE writer (EXE_RegWrite_IN) or MEM writer (MEM_RegWrite_IN) is a hazard writer.
- Writeback is never a hazard in either case, because the register file delivers same-cycle write data.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum (IDLE, DRAIN, NOTIFY, RELEASE);
  - the REG_ZERO constant;
  - default DRAIN_CYCLES.
- One sub-module, hazard_match: the combinational LU compare, instantiated once. The FSM and counters stay in pipeline_hazard_ctrl.

## Test plan
- Load-use:
  - Setup: EXE lw writes $8, ID add reads $8 on A.
  - With FORWARDING_EN: exactly 1 stall cycle, Bubble_EXE=1, StallCount=1.
  - Without FORWARDING_EN: 2 stall cycles, with the writer in EXE then MEM.
- Register 0: EXE lw writes $0, ID reads $0 → no stall.
- Syscall:
  - Setup: syscall in ID at cycle 10, DRAIN_CYCLES=4.
  - Expected: stalls in cycles 10–14, SYS=1 only at 14, RELEASE at 15, StallCount=5.
- LL in ID: same sequence as the syscall case, but SYS stays 0 throughout and DrainActive=1 for cycles 11–15.
- Redirect:
  - ID_Redirect_IN=1 with no hazard → Flush_IF=1 and RedirectCount increments.
  - Redirect concurrent with LU → Flush_IF=0.
- Reset mid-DRAIN: RESET=1 → next cycle state IDLE, all outputs 0, counters 0, no SYS pulse.
